md_unit: RTL
============

Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers, sitting in the EX stage of the pipelined MIPS core.
- Consumes the controller's 3-bit ALUMDctr code and the EX operands; exposes HI/LO to the mfhi/mflo path.
- Raises a busy flag so the hazard unit can stall later MD instructions.
- Supports exception/interrupt flush at issue, so a killed instruction never modifies HI/LO.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, cycles busy stays high for mult/multu; must be >= 1.
- DIV_CYCLES, 10, cycles busy stays high for div/divu; must be >= 1.
- CNT_W, 8, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mtlo, 6 mthi, 7 reserved (treated as none).
- op_a  in  WIDTH  rs value (dividend / multiplicand / mtlo/mthi source).
- op_b  in  WIDTH  rt value (divisor / multiplier).
- flush  in  1  EX instruction is being cancelled (exception/interrupt/eret) this cycle.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse, high in the first cycle the new HI/LO are visible.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset==0 at edge): state IDLE, hi=0, lo=0, busy=0, done=0, cnt=0. Reset overrides everything, including an operation in flight (aborted, result discarded).
- States: IDLE, MUL, DIV. busy = (state != IDLE), decoded from registered state.
- Issue is accepted at an edge only if state==IDLE, flush==0, md_op in 1..6.
- mult/multu/div/divu issue:
  - Operands are latched.
  - The full result {hi_n, lo_n} is computed from the latched operands into a result register.
  - cnt <= MULT_CYCLES or DIV_CYCLES.
  - Next state: MUL or DIV.
- mtlo/mthi issue: lo or hi <= op_a at that edge. No busy, no done, state stays IDLE.
- MUL/DIV state, each edge:
  - cnt decrements.
  - At the edge where cnt==1: hi<=hi_n, lo<=lo_n, done<=1, state<=IDLE.
  - Net effect: busy is high for exactly N cycles; hi/lo change and done pulses in the cycle busy falls.
- done is 0 in every cycle other than that one.
- md_op while busy: ignored, with no latching and no effect. The hazard unit must stall; the block does not queue.
- flush while busy: no effect. An already-issued MD operation always completes, per MIPS semantics.
- flush with an issuing md_op: issue suppressed, hi/lo unchanged, state stays IDLE.
- mult: signed WIDTH x WIDTH -> 2*WIDTH; hi = upper half, lo = lower half.
- multu: same as mult, unsigned.
- div: signed, quotient -> lo, remainder -> hi, truncating toward zero; remainder takes the sign of the dividend.
- divu: same as div, unsigned.
- Divide by zero (div or divu): lo = all ones, hi = op_a.
- Signed overflow (div with op_a = MIN, op_b = -1): lo = MIN, hi = 0.
- hi/lo outputs are the registers directly. An mfhi/mflo reading in the done cycle sees the new values.

Test Plan:
- Reset, then mult op_a=0xFFFFFFFF (-1), op_b=2 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulses 1 cycle.
- multu op_a=0xFFFFFFFF, op_b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- div op_a=-7 (0xFFFFFFF9), op_b=2:
  - Result: lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles.
  - divu 7/0 -> lo=0xFFFFFFFF, hi=7.
  - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- mtlo 0x1234 with flush=1 -> lo unchanged (0); next cycle mtlo 0x1234 with flush=0 -> lo=0x1234, busy stays 0.
- Start div, then assert flush and md_op=mthi during busy cycles 2..4 -> div result still written at cycle 10; mthi has no effect.
- Start mult, drive reset=0 at busy cycle 3 -> next cycle busy=0, hi=lo=0, done never pulses.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// The result is computed at issue; busy models the latency, then HI/LO update with a done pulse.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic [WIDTH-1:0]   div_q;
    logic [WIDTH-1:0]   div_r;
    logic               issue;

    // Issue contract: an op is taken only at an edge where the unit is idle
    // and the EX instruction is not being flushed; anything else is dropped,
    // the hazard unit is expected to hold the instruction while busy is high.
    assign issue = (state == IDLE) && !flush && (md_op >= OP_MULT) && (md_op <= OP_MTHI);
    assign busy  = (state != IDLE);

    always_comb begin
        prod_s = $signed({{WIDTH{op_a[WIDTH-1]}}, op_a}) * $signed({{WIDTH{op_b[WIDTH-1]}}, op_b});
        prod_u = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
        div_q  = '1;
        div_r  = op_a;
        // Divide-by-zero and MIN/-1 get fixed results instead of relying on the operator.
        if (op_b == '0) begin
            div_q = '1;
            div_r = op_a;
        end else if (md_op == OP_DIV) begin
            if (op_a == MIN_VAL && op_b == '1) begin
                div_q = MIN_VAL;
                div_r = '0;
            end else begin
                div_q = $signed(op_a) / $signed(op_b);
                div_r = $signed(op_a) % $signed(op_b);
            end
        end else begin
            div_q = op_a / op_b;
            div_r = op_a % op_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            hi_n  <= '0;
            lo_n  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        unique case (md_op)
                            OP_MULT: begin
                                {hi_n, lo_n} <= prod_s;
                                cnt          <= CNT_W'(MULT_CYCLES);
                                state        <= MUL;
                            end
                            OP_MULTU: begin
                                {hi_n, lo_n} <= prod_u;
                                cnt          <= CNT_W'(MULT_CYCLES);
                                state        <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                hi_n  <= div_r;
                                lo_n  <= div_q;
                                cnt   <= CNT_W'(DIV_CYCLES);
                                state <= DIV;
                            end
                            OP_MTLO: lo <= op_a;
                            OP_MTHI: hi <= op_a;
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        hi    <= hi_n;
                        lo    <= lo_n;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
